vga_scan_timing: RTL and testbench

- Generates the raster scan for the game display: pixel-enable strobe, column/row counters, active-low HS/VS syncs, blank, and a frame-start pulse.
- Default timing is 640x480 @ 60 Hz from a 50 MHz board clock divided by 2.
- Its col/row outputs feed directly into the RangeCheck/OffsetCheck stages that decide whether a pixel lies inside a sprite, lane, or obstacle box.

---
 rtl/vga_scan_timing.sv | 136 +++++++++++++
 tb/tb_vga_scan_timing.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_scan_timing.sv
// vga_scan_timing: raster scan generator for the game display.
// Produces the pixel-enable strobe, column/row counters, active-low HS/VS,
// blank and a frame-start pulse. Default timing is 640x480 @ 60 Hz with a
// 50 MHz clock divided by 2.
// Optional feature macro: VGA_FRAME_COUNT_EN adds a 16-bit frame counter
// output (frame_cnt) that advances on every frame_start pulse.
`timescale 1ns/1ps
module vga_scan_timing #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int CLK_DIV   = 2,
  localparam int H_TOTAL  = H_VISIBLE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL  = V_VISIBLE + V_FP + V_SYNC + V_BP,
  localparam int CW       = $clog2(H_TOTAL),
  localparam int RW       = $clog2(V_TOTAL)
) (
  input  logic          clock,
  input  logic          reset,
  output logic          pix_en,
  output logic [CW-1:0] col,
  output logic [RW-1:0] row,
  output logic          HS,
  output logic          VS,
  output logic          blank,
  output logic          frame_start
`ifdef VGA_FRAME_COUNT_EN
  ,
  output logic [15:0]   frame_cnt
`endif
);

  // Divider width; a one-bit counter that stays at 0 covers CLK_DIV=1.
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(H_TOTAL - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(V_TOTAL - 1);

  // Decode boundaries carry one spare bit so an end bound equal to a power
  // of two (e.g. zero back porch) still compares correctly.
  localparam logic [CW:0] H_VIS_C  = (CW+1)'(H_VISIBLE);
  localparam logic [CW:0] HS_START = (CW+1)'(H_VISIBLE + H_FP);
  localparam logic [CW:0] HS_END   = (CW+1)'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [RW:0] V_VIS_C  = (RW+1)'(V_VISIBLE);
  localparam logic [RW:0] VS_START = (RW+1)'(V_VISIBLE + V_FP);
  localparam logic [RW:0] VS_END   = (RW+1)'(V_VISIBLE + V_FP + V_SYNC);

  logic [DW-1:0] div_q, div_d;
  logic          pix_en_q, pix_en_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          row_step;

  // Next-state: divider wrap, strobe decode, column advance and row step.
  always_comb begin
    div_d    = div_q;
    pix_en_d = 1'b0;
    col_d    = col_q;
    row_d    = row_q;
    row_step = 1'b0;

    if (div_q == DIV_LAST) begin
      div_d = '0;
    end else begin
      div_d = div_q + DW'(1);
    end
    // Registered decode: the strobe appears the cycle after div hits its last value.
    pix_en_d = (div_q == DIV_LAST);

    if (pix_en_q) begin
      if (col_q == COL_LAST) begin
        col_d    = '0;
        row_step = 1'b1;
      end else begin
        col_d = col_q + CW'(1);
      end
    end

    if (row_step) begin
      if (row_q == ROW_LAST) begin
        row_d = '0;
      end else begin
        row_d = row_q + RW'(1);
      end
    end
  end

  // State registers; reset abandons any partial line or frame immediately.
  always_ff @(posedge clock) begin
    if (reset) begin
      div_q    <= '0;
      pix_en_q <= 1'b0;
      col_q    <= '0;
      row_q    <= '0;
    end else begin
      div_q    <= div_d;
      pix_en_q <= pix_en_d;
      col_q    <= col_d;
      row_q    <= row_d;
    end
  end

  // Zero-latency sync/blank/frame decode from the registered counters.
  always_comb begin
    HS          = !(({1'b0, col_q} >= HS_START) && ({1'b0, col_q} < HS_END));
    VS          = !(({1'b0, row_q} >= VS_START) && ({1'b0, row_q} < VS_END));
    blank       = ({1'b0, col_q} >= H_VIS_C) || ({1'b0, row_q} >= V_VIS_C);
    frame_start = pix_en_q && (col_q == '0) && (row_q == '0);
  end

  assign pix_en = pix_en_q;
  assign col    = col_q;
  assign row    = row_q;

`ifdef VGA_FRAME_COUNT_EN
  logic [15:0] frame_cnt_q;

  // Frame counter: one step per frame_start, natural 16-bit wrap.
  always_ff @(posedge clock) begin
    if (reset) begin
      frame_cnt_q <= '0;
    end else if (frame_start) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_scan_timing.sv
// Bench for vga_scan_timing: a table of hand-derived checkpoints on the
// default 640x480 timing, randomized resets on two small-geometry instances
// checked against an arithmetic scan model, and a few multi-cycle sequences.
`timescale 1ns/1ps
module tb_vga_scan_timing;

  // Small geometry: H_TOTAL = 15, V_TOTAL = 11.
  localparam int S_HV = 8, S_HF = 2, S_HS = 3, S_HB = 2;
  localparam int S_VV = 6, S_VF = 1, S_VS = 2, S_VB = 2;

  typedef struct packed {
    int   col;
    int   row;
    logic hs;
    logic vs;
    logic blank;
    logic pix;
    logic fs;
  } exp_t;

  typedef struct {
    int   n;
    exp_t e;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst1, rst2;
  logic       pix0, hs0, vs0, blank0, fs0;
  logic [9:0] col0, row0;
  logic       pix1, hs1, vs1, blank1, fs1;
  logic [3:0] col1, row1;
  logic       pix2, hs2, vs2, blank2, fs2;
  logic [3:0] col2, row2;
`ifdef VGA_FRAME_COUNT_EN
  logic [15:0] fc0, fc1, fc2;
  logic [15:0] fcm1, fcm2;
`endif

  int checks   = 0;
  int failures = 0;

  vga_scan_timing dut0 (
    .clock(clk), .reset(rst0), .pix_en(pix0), .col(col0), .row(row0),
    .HS(hs0), .VS(vs0), .blank(blank0), .frame_start(fs0)
`ifdef VGA_FRAME_COUNT_EN
    , .frame_cnt(fc0)
`endif
  );

  vga_scan_timing #(
    .H_VISIBLE(S_HV), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
    .V_VISIBLE(S_VV), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB), .CLK_DIV(3)
  ) dut1 (
    .clock(clk), .reset(rst1), .pix_en(pix1), .col(col1), .row(row1),
    .HS(hs1), .VS(vs1), .blank(blank1), .frame_start(fs1)
`ifdef VGA_FRAME_COUNT_EN
    , .frame_cnt(fc1)
`endif
  );

  vga_scan_timing #(
    .H_VISIBLE(S_HV), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
    .V_VISIBLE(S_VV), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB), .CLK_DIV(1)
  ) dut2 (
    .clock(clk), .reset(rst2), .pix_en(pix2), .col(col2), .row(row2),
    .HS(hs2), .VS(vs2), .blank(blank2), .frame_start(fs2)
`ifdef VGA_FRAME_COUNT_EN
    , .frame_cnt(fc2)
`endif
  );

  function automatic exp_t mk(input int c, input int r, input logic h, input logic v,
                              input logic b, input logic p, input logic f);
    exp_t e;
    e.col = c; e.row = r; e.hs = h; e.vs = v; e.blank = b; e.pix = p; e.fs = f;
    return e;
  endfunction

  // Scan model: n = clock edges since reset was last sampled high.
  // Strobes land on n = D, 2D, ...; each strobe advances one pixel on its edge,
  // so the pixel index is the number of strobes strictly before cycle n.
  function automatic exp_t model(input int hv, input int hf, input int hsw, input int hb,
                                 input int vv, input int vf, input int vsw, input int vb,
                                 input int dv, input int n);
    int ht, vt, pc;
    exp_t e;
    ht = hv + hf + hsw + hb;
    vt = vv + vf + vsw + vb;
    pc = (n == 0) ? 0 : (n - 1) / dv;
    e.pix   = (n >= 1) && (n % dv == 0);
    e.col   = pc % ht;
    e.row   = (pc / ht) % vt;
    e.hs    = !((e.col >= hv + hf) && (e.col < hv + hf + hsw));
    e.vs    = !((e.row >= vv + vf) && (e.row < vv + vf + vsw));
    e.blank = (e.col >= hv) || (e.row >= vv);
    e.fs    = e.pix && (e.col == 0) && (e.row == 0);
    return e;
  endfunction

  function automatic exp_t m1(input int n);
    return model(S_HV, S_HF, S_HS, S_HB, S_VV, S_VF, S_VS, S_VB, 3, n);
  endfunction

  function automatic exp_t m2(input int n);
    return model(S_HV, S_HF, S_HS, S_HB, S_VV, S_VF, S_VS, S_VB, 1, n);
  endfunction

  task automatic check(input string name, input int n, input exp_t got, input exp_t want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s n=%0d got col=%0d row=%0d hs=%0b vs=%0b blank=%0b pix=%0b fs=%0b want col=%0d row=%0d hs=%0b vs=%0b blank=%0b pix=%0b fs=%0b",
               name, n, got.col, got.row, got.hs, got.vs, got.blank, got.pix, got.fs,
               want.col, want.row, want.hs, want.vs, want.blank, want.pix, want.fs);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  function automatic exp_t act0();
    return mk(int'(col0), int'(row0), hs0, vs0, blank0, pix0, fs0);
  endfunction
  function automatic exp_t act1();
    return mk(int'(col1), int'(row1), hs1, vs1, blank1, pix1, fs1);
  endfunction
  function automatic exp_t act2();
    return mk(int'(col2), int'(row2), hs2, vs2, blank2, pix2, fs2);
  endfunction

  vec_t tbl[$];

  task automatic add(input int n, input int c, input int r, input logic h, input logic v,
                     input logic b, input logic p, input logic f);
    vec_t t;
    t.n = n;
    t.e = mk(c, r, h, v, b, p, f);
    tbl.push_back(t);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, n1, n2, idx, k, vs_low, blank_cnt, rl1, rl2;
    bit found;
    exp_t rst_exp;

    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
    rst_exp = mk(0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    // Default-geometry checkpoints, n counted from reset release (CLK_DIV=2).
    //   n   col  row hs vs blank pix fs
    add(0,     0, 0, 1, 1, 0, 0, 0);
    add(1,     0, 0, 1, 1, 0, 0, 0);
    add(2,     0, 0, 1, 1, 0, 1, 1);
    add(3,     1, 0, 1, 1, 0, 0, 0);
    add(4,     1, 0, 1, 1, 0, 1, 0);
    add(1279, 639, 0, 1, 1, 0, 0, 0);
    add(1281, 640, 0, 1, 1, 1, 0, 0);
    add(1311, 655, 0, 1, 1, 1, 0, 0);
    add(1313, 656, 0, 0, 1, 1, 0, 0);
    add(1503, 751, 0, 0, 1, 1, 0, 0);
    add(1505, 752, 0, 1, 1, 1, 0, 0);
    add(1600, 799, 0, 1, 1, 1, 1, 0);
    add(1601,   0, 1, 1, 1, 0, 0, 0);
    add(1602,   0, 1, 1, 1, 0, 1, 0);
    add(3201,   0, 2, 1, 1, 0, 0, 0);

    // Reset hold: outputs sit at their reset values.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("reset_hold_d2", i, act0(), rst_exp);
      check("reset_hold_d3", i, act1(), rst_exp);
`ifdef VGA_FRAME_COUNT_EN
      check_int("reset_hold_frame_cnt", int'(fc0), 0);
`endif
    end

    // Table-driven line timing on the default geometry.
    rst0 = 1'b0;
    n = 0;
    idx = 0;
    while (idx < tbl.size()) begin
      if (tbl[idx].n == n) begin
        check("line_vec", n, act0(), tbl[idx].e);
        $display("vec %0d n=%0d col=%0d row=%0d hs=%0b blank=%0b pix=%0b fs=%0b",
                 idx, n, col0, row0, hs0, blank0, pix0, fs0);
        idx++;
      end else begin
        @(negedge clk);
        n++;
      end
    end

    // Randomized resets on the small instances against the scan model.
    rst1 = 1'b0; rst2 = 1'b0;
    n1 = 0; n2 = 0; rl1 = 0; rl2 = 0;
`ifdef VGA_FRAME_COUNT_EN
    fcm1 = '0; fcm2 = '0;
`endif
    for (int cyc = 0; cyc < 15000; cyc++) begin
      @(posedge clk);
`ifdef VGA_FRAME_COUNT_EN
      if (rst1) fcm1 = '0; else if (m1(n1).fs) fcm1 = fcm1 + 16'd1;
      if (rst2) fcm2 = '0; else if (m2(n2).fs) fcm2 = fcm2 + 16'd1;
`endif
      n1 = rst1 ? 0 : n1 + 1;
      n2 = rst2 ? 0 : n2 + 1;
      @(negedge clk);
      check("rand_div3", n1, act1(), m1(n1));
      check("rand_div1", n2, act2(), m2(n2));
`ifdef VGA_FRAME_COUNT_EN
      check_int("rand_frame_cnt_div3", int'(fc1), int'(fcm1));
      check_int("rand_frame_cnt_div1", int'(fc2), int'(fcm2));
`endif
      if (rl1 > 0) rl1--; else if ($urandom_range(1999, 0) == 0) rl1 = $urandom_range(3, 1);
      if (rl2 > 0) rl2--; else if ($urandom_range(1999, 0) == 0) rl2 = $urandom_range(3, 1);
      rst1 = (rl1 > 0);
      rst2 = (rl2 > 0);
    end
    rst1 = 1'b0; rst2 = 1'b0;

    // Frame period, VS-low and blank cycle counts over one frame (CLK_DIV=3).
    found = 1'b0;
    for (int i = 0; i < 1200 && !found; i++) begin
      @(negedge clk);
      if (fs1) found = 1'b1;
    end
    check_int("first_frame_start_seen", int'(found), 1);
    k = 0; vs_low = int'(!vs1); blank_cnt = int'(blank1); found = 1'b0;
    while (k < 1200 && !found) begin
      @(negedge clk);
      k++;
      if (fs1) found = 1'b1;
      else begin
        vs_low    += int'(!vs1);
        blank_cnt += int'(blank1);
      end
    end
    check_int("frame_start_spacing", k, 15 * 11 * 3);
    check_int("vs_low_clocks", vs_low, S_VS * 15 * 3);
    check_int("blank_clocks", blank_cnt, (15 * 11 - S_HV * S_VV) * 3);
    $display("frame seq period=%0d vs_low=%0d blank=%0d", k, vs_low, blank_cnt);

    // Mid-frame reset: one-cycle pulse at row 3 col 5, frame restarts.
    found = 1'b0;
    for (int i = 0; i < 1200 && !found; i++) begin
      @(negedge clk);
      if (row1 == 4'd3 && col1 == 4'd5) found = 1'b1;
    end
    check_int("midreset_point_seen", int'(found), 1);
    rst1 = 1'b1;
    @(negedge clk);
    rst1 = 1'b0;
    check("midreset_state", 0, act1(), rst_exp);
`ifdef VGA_FRAME_COUNT_EN
    check_int("midreset_frame_cnt", int'(fc1), 0);
`endif
    k = 0; found = 1'b0;
    while (k < 20 && !found) begin
      @(negedge clk);
      k++;
      if (fs1) found = 1'b1;
    end
    check_int("midreset_fs_delay", k, 3);
`ifdef VGA_FRAME_COUNT_EN
    @(negedge clk);
    check_int("midreset_frame_cnt_after", int'(fc1), 1);
`endif
    $display("midreset seq fs_delay=%0d", k);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
